bot_cmd_decoder: RTL and testbench

BOT_CMD_DECODER -- requirements
Module: bot_cmd_decoder

---
 rtl/bot_cmd_decoder.sv | 158 +++++++++++++++
 tb/tb_bot_cmd_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bot_cmd_decoder.sv
// IR command byte decoder: frame detect, IDLE/RUN/BRAKE FSM, watchdog and motor drive.
// Define BOT_CMD_PWM_EN to build the PWM speed gating on the RUN outputs.
module bot_cmd_decoder #(
  parameter logic [15:0] PWM_PRESC   = 16'd312,
  parameter logic [31:0] WDOG_TICKS  = 32'd16_000_000,
  parameter logic [23:0] BRAKE_TICKS = 24'd8_000_000
) (
  input  logic       clk80,
  input  logic       reset_n,
  input  logic [7:0] rbyte,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic [1:0] speed,
  output logic [1:0] state,
  output logic       cmd_strobe
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BRAKE = 2'b10
  } state_e;

  localparam logic [2:0] C_STOP   = 3'd0;
  localparam logic [2:0] C_FWD    = 3'd1;
  localparam logic [2:0] C_BACK   = 3'd2;
  localparam logic [2:0] C_LEFT   = 3'd3;
  localparam logic [2:0] C_RIGHT  = 3'd4;
  localparam logic [2:0] C_SPD_UP = 3'd5;
  localparam logic [2:0] C_SPD_DN = 3'd6;
  localparam logic [2:0] C_BRAKE  = 3'd7;

  state_e      state_p1;
  state_e      state_nxt;
  logic [7:0]  rbyte_q;
  logic        vld_p0;
  logic [2:0]  code_p0;
  logic [1:0]  dir_l_p1;
  logic [1:0]  dir_r_p1;
  logic [31:0] wdog_p1;
  logic [23:0] brk_p1;
  logic        pwm_on;
  logic [1:0]  mot_l_nxt;
  logic [1:0]  mot_r_nxt;

  // The sender flips bit 7 each frame, so any change with a valid tag is a new frame.
  assign vld_p0  = (rbyte != rbyte_q) && (rbyte[3:0] == 4'h5);
  assign code_p0 = rbyte[6:4];
  assign state   = state_p1;

  // Stage 0 -> 1: frame capture, direction/speed latch and timers
  always_ff @(posedge clk80 or negedge reset_n) begin
    if (!reset_n) begin
      rbyte_q    <= 8'h00;
      cmd_strobe <= 1'b0;
      speed      <= 2'd2;
      dir_l_p1   <= 2'b00;
      dir_r_p1   <= 2'b00;
      wdog_p1    <= 32'd0;
      brk_p1     <= 24'd0;
    end else begin
      rbyte_q    <= rbyte;
      cmd_strobe <= vld_p0;
      if (vld_p0)
        wdog_p1 <= WDOG_TICKS - 32'd1;
      else if (state_p1 == ST_RUN && wdog_p1 != 32'd0)
        wdog_p1 <= wdog_p1 - 32'd1;
      if (vld_p0 && code_p0 == C_BRAKE)
        brk_p1 <= BRAKE_TICKS - 24'd1;
      else if (state_p1 == ST_BRAKE && brk_p1 != 24'd0)
        brk_p1 <= brk_p1 - 24'd1;
      if (vld_p0) begin
        case (code_p0)
          C_FWD:    begin dir_l_p1 <= 2'b10; dir_r_p1 <= 2'b10; end
          C_BACK:   begin dir_l_p1 <= 2'b01; dir_r_p1 <= 2'b01; end
          C_LEFT:   begin dir_l_p1 <= 2'b01; dir_r_p1 <= 2'b10; end
          C_RIGHT:  begin dir_l_p1 <= 2'b10; dir_r_p1 <= 2'b01; end
          C_SPD_UP: if (speed != 2'd3) speed <= speed + 2'd1;
          C_SPD_DN: if (speed != 2'd0) speed <= speed - 2'd1;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk80 or negedge reset_n) begin
    if (!reset_n) state_p1 <= ST_IDLE;
    else          state_p1 <= state_nxt;
  end

  // An accepted frame wins over watchdog or brake expiry in the same cycle.
  always_comb begin
    state_nxt = state_p1;
    if (vld_p0) begin
      case (code_p0)
        C_STOP:                          state_nxt = ST_IDLE;
        C_FWD, C_BACK, C_LEFT, C_RIGHT:  state_nxt = ST_RUN;
        C_BRAKE:                         state_nxt = ST_BRAKE;
        default:                         state_nxt = state_p1;
      endcase
    end else begin
      case (state_p1)
        ST_RUN:   if (wdog_p1 == 32'd0) state_nxt = ST_IDLE;
        ST_BRAKE: if (brk_p1 == 24'd0)  state_nxt = ST_IDLE;
        default:  state_nxt = state_p1;
      endcase
    end
  end

`ifdef BOT_CMD_PWM_EN
  logic [15:0] presc_p1;
  logic [7:0]  pwm_cnt_p1;

  always_ff @(posedge clk80 or negedge reset_n) begin
    if (!reset_n) begin
      presc_p1   <= 16'd0;
      pwm_cnt_p1 <= 8'd0;
    end else if (presc_p1 == PWM_PRESC - 16'd1) begin
      presc_p1   <= 16'd0;
      pwm_cnt_p1 <= pwm_cnt_p1 + 8'd1;
    end else begin
      presc_p1   <= presc_p1 + 16'd1;
    end
  end

  assign pwm_on = (pwm_cnt_p1 <= {speed, 6'h3F});
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    mot_l_nxt = 2'b00;
    mot_r_nxt = 2'b00;
    case (state_p1)
      ST_BRAKE: begin
        mot_l_nxt = 2'b11;
        mot_r_nxt = 2'b11;
      end
      ST_RUN: if (pwm_on) begin
        mot_l_nxt = dir_l_p1;
        mot_r_nxt = dir_r_p1;
      end
      default: ;
    endcase
  end

  // Stage 1 -> 2: registered motor drive
  always_ff @(posedge clk80 or negedge reset_n) begin
    if (!reset_n) begin
      motor_l <= 2'b00;
      motor_r <= 2'b00;
    end else begin
      motor_l <= mot_l_nxt;
      motor_r <= mot_r_nxt;
    end
  end

endmodule

// File: tb/tb_bot_cmd_decoder.sv
// Directed bench for bot_cmd_decoder with short timer parameters.
module tb_bot_cmd_decoder;

  logic       clk80 = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] rbyte = 8'h00;
  logic [1:0] motor_l;
  logic [1:0] motor_r;
  logic [1:0] speed;
  logic [1:0] state;
  logic       cmd_strobe;

  int checks = 0;
  int errors = 0;
  int on_cnt;
  int brk_cnt;
  int exp_duty0;
  logic tgl;

  bot_cmd_decoder #(
    .PWM_PRESC  (16'd2),
    .WDOG_TICKS (32'd100),
    .BRAKE_TICKS(24'd20)
  ) dut (
    .clk80     (clk80),
    .reset_n   (reset_n),
    .rbyte     (rbyte),
    .motor_l   (motor_l),
    .motor_r   (motor_r),
    .speed     (speed),
    .state     (state),
    .cmd_strobe(cmd_strobe)
  );

  always #5 clk80 = ~clk80;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk80);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    rbyte = b;
    tick(1);
    chk(tag, {31'd0, cmd_strobe}, 32'd1);
  endtask

  task automatic measure_duty(input logic t0);
    tgl = t0;
    on_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      if (i % 50 == 25) begin
        rbyte = {tgl, 7'h15};
        tgl = ~tgl;
      end
      tick(1);
      if (motor_l == 2'b10 && motor_r == 2'b10) on_cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef BOT_CMD_PWM_EN
    exp_duty0 = 128;
`else
    exp_duty0 = 512;
`endif
    // Reset state
    #2 reset_n = 1'b0;
    tick(3);
    chk("rst_motor_l", {30'd0, motor_l}, 32'h0);
    chk("rst_motor_r", {30'd0, motor_r}, 32'h0);
    chk("rst_state", {30'd0, state}, 32'h0);
    chk("rst_strobe", {31'd0, cmd_strobe}, 32'h0);
    chk("rst_speed", {30'd0, speed}, 32'd2);
    reset_n = 1'b1;
    tick(2);

    // Scenario 1: first forward frame
    send(8'h15, "s1_strobe");
    chk("s1_state", {30'd0, state}, 32'h1);
    chk("s1_motor_latency", {28'd0, motor_l, motor_r}, 32'h0);
    tick(1);
    chk("s1_strobe_low", {31'd0, cmd_strobe}, 32'h0);
    chk("s1_motor_fwd", {28'd0, motor_l, motor_r}, 32'hA);

    // Scenario 2: repeated forward with toggle bit
    send(8'h95, "s2_strobe_a");
    chk("s2_state_a", {30'd0, state}, 32'h1);
    tick(1);
    chk("s2_strobe_gap", {31'd0, cmd_strobe}, 32'h0);
    send(8'h15, "s2_strobe_b");
    chk("s2_state_b", {30'd0, state}, 32'h1);

    // Speed up in RUN keeps direction; then left turn
    send(8'h55, "spd_up_strobe");
    chk("spd_up_speed", {30'd0, speed}, 32'd3);
    chk("spd_up_state", {30'd0, state}, 32'h1);
    tick(1);
    chk("spd_up_motor", {28'd0, motor_l, motor_r}, 32'hA);
    send(8'hB5, "left_strobe");
    tick(1);
    chk("left_motor", {28'd0, motor_l, motor_r}, 32'h6);

    // Scenario 3: watchdog expiry
    send(8'h15, "wd_strobe");
    tick(99);
    chk("wd_still_run", {30'd0, state}, 32'h1);
    tick(1);
    chk("wd_idle", {30'd0, state}, 32'h0);
    tick(1);
    chk("wd_motor_off", {28'd0, motor_l, motor_r}, 32'h0);
    send(8'h95, "wd2_strobe");
    tick(99);
    chk("wd2_before_exp", {30'd0, state}, 32'h1);
    send(8'h15, "wd2_exp_frame");
    chk("wd2_kept_run", {30'd0, state}, 32'h1);
    tick(1);
    chk("wd2_motor", {28'd0, motor_l, motor_r}, 32'hA);

    // Scenario 4: brake for 20 cycles, then abort a second brake with right
    send(8'h75, "brk_strobe");
    chk("brk_state", {30'd0, state}, 32'h2);
    tick(1);
    brk_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (motor_l == 2'b11 && motor_r == 2'b11) brk_cnt++;
      tick(1);
    end
    chk("brk_cycles", brk_cnt, 32'd20);
    chk("brk_end_motor", {28'd0, motor_l, motor_r}, 32'h0);
    chk("brk_end_state", {30'd0, state}, 32'h0);
    send(8'hF5, "brk2_strobe");
    chk("brk2_state", {30'd0, state}, 32'h2);
    tick(5);
    send(8'hC5, "abort_strobe");
    chk("abort_state", {30'd0, state}, 32'h1);
    tick(1);
    chk("abort_motor_right", {28'd0, motor_l, motor_r}, 32'h9);

    // Scenario 5: speed saturation and duty
    send(8'h65, "dn1");
    chk("dn1_speed", {30'd0, speed}, 32'd2);
    send(8'hE5, "dn2");
    chk("dn2_speed", {30'd0, speed}, 32'd1);
    send(8'h65, "dn3");
    chk("dn3_speed", {30'd0, speed}, 32'd0);
    send(8'hE5, "dn4");
    chk("dn4_speed_sat", {30'd0, speed}, 32'd0);
    chk("dn4_state", {30'd0, state}, 32'h1);
    send(8'h15, "duty0_fwd");
    tick(3);
    measure_duty(1'b1);
    chk("duty_speed0", on_cnt, exp_duty0);
    send(8'h55, "up1");
    chk("up1_speed", {30'd0, speed}, 32'd1);
    send(8'hD5, "up2");
    chk("up2_speed", {30'd0, speed}, 32'd2);
    send(8'h55, "up3");
    chk("up3_speed", {30'd0, speed}, 32'd3);
    send(8'hD5, "up4");
    chk("up4_speed_sat", {30'd0, speed}, 32'd3);
    send(8'h95, "duty3_fwd");
    tick(3);
    measure_duty(1'b0);
    chk("duty_speed3", on_cnt, 32'd512);

    // Ignored frame: no strobe and no watchdog refresh
    send(8'h15, "ign_arm");
    tick(49);
    rbyte = 8'h14;
    tick(1);
    chk("ign_no_strobe", {31'd0, cmd_strobe}, 32'h0);
    tick(49);
    chk("ign_run", {30'd0, state}, 32'h1);
    tick(1);
    chk("ign_wd_idle", {30'd0, state}, 32'h0);

    // Scenario 6: asynchronous reset mid-RUN
    send(8'h15, "s6_strobe");
    tick(1);
    chk("s6_motor_run", {28'd0, motor_l, motor_r}, 32'hA);
    #2;
    reset_n = 1'b0;
    rbyte = 8'h00;
    #1;
    chk("s6_async_motor", {28'd0, motor_l, motor_r}, 32'h0);
    chk("s6_async_state", {30'd0, state}, 32'h0);
    chk("s6_async_speed", {30'd0, speed}, 32'd2);
    #2;
    reset_n = 1'b1;
    tick(2);
    chk("s6_rel_state", {30'd0, state}, 32'h0);
    chk("s6_rel_speed", {30'd0, speed}, 32'd2);
    chk("s6_rel_motor", {28'd0, motor_l, motor_r}, 32'h0);
    chk("s6_rel_strobe", {31'd0, cmd_strobe}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
